// File: rtl/vector_fetch_engine.sv
// Vector fetch engine: pops test-vector addresses, reads BEATS_PER_VCTR words per address
// from the bus master and pushes them into the vector FIFO. Optional macro: FETCH_TIMEOUT_EN.
module vector_fetch_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int BEATS_PER_VCTR = 1,
  parameter int ADDR_STRIDE    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_program,
  input  logic                  end_program,
  input  logic [DATA_WIDTH-1:0] addr_fifo_dout,
  input  logic                  addr_fifo_empty,
  output logic                  addr_fifo_rd,
  output logic [31:0]           master_addr,
  output logic                  master_rd,
  input  logic [DATA_WIDTH-1:0] master_data_in,
  input  logic                  master_data_in_val,
  output logic [DATA_WIDTH-1:0] vctr_fifo_din,
  output logic                  vctr_fifo_wr,
  input  logic                  vector_fifo_full,
  output logic                  fetch_busy,
  output logic                  fetch_done,
  output logic [15:0]           vctr_fetch_cnt,
  output logic                  unexpected_rsp_err
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  // state  | meaning
  // IDLE   | nothing in flight, waiting for run_program and a queued address
  // POP    | addr_fifo_rd strobe
  // LOAD   | capture popped address, reset beat counter
  // REQ    | issue master read once the vector FIFO has room
  // WAIT   | single outstanding read, waiting for its response
  // PUSH   | write captured word into the vector FIFO, pick next beat/address
  typedef enum logic [2:0] {S_IDLE, S_POP, S_LOAD, S_REQ, S_WAIT, S_PUSH} state_t;

  state_t      state, state_nxt;
  logic [8:0]  beat;
  logic [31:0] cur_addr;
  logic        reset_hold;
  logic        last_beat;
  logic        wait_expired;

  if (BEATS_PER_VCTR < 1 || BEATS_PER_VCTR > 256 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("vector_fetch_engine: parameter out of range");
  end

  assign last_beat   = (beat == 9'(BEATS_PER_VCTR - 1));
  assign master_addr = cur_addr;
  assign fetch_busy  = (state != S_IDLE);

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt;

  // Down-counter loaded on issue; terminal count in WAIT means TIMEOUT_CYCLES silent cycles
  assign wait_expired = (state == S_WAIT) && (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (master_rd)
        wait_cnt <= TW'(TIMEOUT_CYCLES - 1);
      else if (state == S_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - TW'(1);
      if (wait_expired && !master_data_in_val)
        timeout_err <= 1'b1;
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    addr_fifo_rd = 1'b0;
    master_rd    = 1'b0;
    vctr_fifo_wr = 1'b0;
    case (state)
      S_IDLE: if (run_program && !addr_fifo_empty) state_nxt = S_POP;
      S_POP: begin
        if (addr_fifo_empty) begin
          state_nxt = S_IDLE;
        end else begin
          addr_fifo_rd = 1'b1;
          state_nxt    = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_REQ;
      S_REQ: begin
        if (!vector_fifo_full) begin
          master_rd = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: if (master_data_in_val || wait_expired) state_nxt = S_PUSH;
      S_PUSH: begin
        vctr_fifo_wr = 1'b1;
        if (!last_beat)
          state_nxt = S_REQ;
        else if (run_program && !addr_fifo_empty)
          state_nxt = S_POP;
        else
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat               <= '0;
      cur_addr           <= '0;
      vctr_fifo_din      <= '0;
      vctr_fetch_cnt     <= '0;
      unexpected_rsp_err <= 1'b0;
      fetch_done         <= 1'b0;
      reset_hold         <= 1'b1;
    end else begin
      reset_hold <= 1'b0;
      fetch_done <= end_program && (state == S_IDLE) && addr_fifo_empty;

      if (state == S_LOAD) begin
        cur_addr <= 32'(addr_fifo_dout);
        beat     <= '0;
      end

      if (state == S_PUSH) begin
        vctr_fetch_cnt <= vctr_fetch_cnt + 16'd1;
        if (!last_beat) begin
          beat     <= beat + 9'd1;
          cur_addr <= cur_addr + 32'(ADDR_STRIDE);
        end
      end

      // A real response wins over a timeout landing in the same cycle
      if (state == S_WAIT && master_data_in_val)
        vctr_fifo_din <= master_data_in;
      else if (wait_expired)
        vctr_fifo_din <= DATA_WIDTH'(32'hDEADBEEF);

      // Stragglers from a burst abandoned by reset are ignored for one cycle
      if (master_data_in_val && state != S_WAIT && !reset_hold)
        unexpected_rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vector_fetch_engine.sv
// Directed testbench for vector_fetch_engine; build with +define+FETCH_TIMEOUT_EN to cover the timeout path.
module tb_vector_fetch_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_program = 1'b0;
  logic        end_program = 1'b0;
  logic [31:0] addr_fifo_dout = '0;
  logic        addr_fifo_empty = 1'b1;
  logic        addr_fifo_rd;
  logic [31:0] master_addr;
  logic        master_rd;
  logic [31:0] master_data_in = '0;
  logic        master_data_in_val = 1'b0;
  logic [31:0] vctr_fifo_din;
  logic        vctr_fifo_wr;
  logic        vector_fifo_full = 1'b0;
  logic        fetch_busy;
  logic        fetch_done;
  logic [15:0] vctr_fetch_cnt;
  logic        unexpected_rsp_err;

  logic        s_empty = 1'b1;
  logic        s_rd;
  logic [31:0] s_maddr;
  logic        s_mrd;
  logic [31:0] s_mdata = '0;
  logic        s_mval = 1'b0;
  logic [31:0] s_din;
  logic        s_wr;
  logic        s_busy;
  logic        s_done;
  logic [15:0] s_cnt;
  logic        s_err;
`ifdef FETCH_TIMEOUT_EN
  logic        timeout_err;
  logic        s_timeout_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int rd_count = 0;
  int mrd_count = 0;

  always #5 clk = ~clk;

  vector_fetch_engine #(
    .DATA_WIDTH(32), .BEATS_PER_VCTR(4), .ADDR_STRIDE(4), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk(clk), .reset(reset), .run_program(run_program), .end_program(end_program),
    .addr_fifo_dout(addr_fifo_dout), .addr_fifo_empty(addr_fifo_empty), .addr_fifo_rd(addr_fifo_rd),
    .master_addr(master_addr), .master_rd(master_rd), .master_data_in(master_data_in),
    .master_data_in_val(master_data_in_val), .vctr_fifo_din(vctr_fifo_din), .vctr_fifo_wr(vctr_fifo_wr),
    .vector_fifo_full(vector_fifo_full), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .vctr_fetch_cnt(vctr_fetch_cnt), .unexpected_rsp_err(unexpected_rsp_err)
`ifdef FETCH_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  vector_fetch_engine #(
    .DATA_WIDTH(32), .BEATS_PER_VCTR(1), .ADDR_STRIDE(4), .TIMEOUT_CYCLES(256)
  ) u_dut_single (
    .clk(clk), .reset(reset), .run_program(run_program), .end_program(end_program),
    .addr_fifo_dout(addr_fifo_dout), .addr_fifo_empty(s_empty), .addr_fifo_rd(s_rd),
    .master_addr(s_maddr), .master_rd(s_mrd), .master_data_in(s_mdata),
    .master_data_in_val(s_mval), .vctr_fifo_din(s_din), .vctr_fifo_wr(s_wr),
    .vector_fifo_full(vector_fifo_full), .fetch_busy(s_busy), .fetch_done(s_done),
    .vctr_fetch_cnt(s_cnt), .unexpected_rsp_err(s_err)
`ifdef FETCH_TIMEOUT_EN
    , .timeout_err(s_timeout_err)
`endif
  );

  always @(posedge clk) begin
    if (addr_fifo_rd) rd_count <= rd_count + 1;
    if (master_rd)    mrd_count <= mrd_count + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the pop strobe, then presents the popped word during LOAD
  task automatic load_addr(input logic [31:0] a, input logic fifo_now_empty, input string tag);
    for (int i = 0; i < 40 && addr_fifo_rd !== 1'b1; i++) tick();
    check1({tag, "_pop"}, addr_fifo_rd, 1'b1);
    tick();
    addr_fifo_dout = a;
    if (fifo_now_empty) addr_fifo_empty = 1'b1;
  endtask

  // One beat: find the request, answer one cycle later, check the push
  task automatic do_beat(input logic [31:0] exp_addr, input logic [31:0] data, input string tag);
    for (int i = 0; i < 40 && master_rd !== 1'b1; i++) tick();
    check1({tag, "_rd"}, master_rd, 1'b1);
    check32({tag, "_addr"}, master_addr, exp_addr);
    tick();
    master_data_in     = data;
    master_data_in_val = 1'b1;
    tick();
    master_data_in_val = 1'b0;
    check1({tag, "_wr"}, vctr_fifo_wr, 1'b1);
    check32({tag, "_din"}, vctr_fifo_din, data);
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_busy"}, fetch_busy, 1'b0);
    check1({tag, "_pop"}, addr_fifo_rd, 1'b0);
    check1({tag, "_mrd"}, master_rd, 1'b0);
    check32({tag, "_maddr"}, master_addr, 32'h0);
    check1({tag, "_wr"}, vctr_fifo_wr, 1'b0);
    check32({tag, "_din"}, vctr_fifo_din, 32'h0);
    check32({tag, "_cnt"}, 32'(vctr_fetch_cnt), 32'h0);
    check1({tag, "_done"}, fetch_done, 1'b0);
    check1({tag, "_uerr"}, unexpected_rsp_err, 1'b0);
`ifdef FETCH_TIMEOUT_EN
    check1({tag, "_terr"}, timeout_err, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, mrd0;

    // Reset state
    repeat (3) tick();
    check_all_zero("rst");
    check1("rst_s_busy", s_busy, 1'b0);
    reset = 1'b1;
    tick();

    // Single beat: POP is cycle 1, PUSH lands on cycle 5 with a 1-cycle response
    addr_fifo_dout = 32'h0000_1000;
    s_empty        = 1'b0;
    run_program    = 1'b1;
    tick();
    check1("t1_pop", s_rd, 1'b1);
    tick();
    s_empty = 1'b1;
    check1("t1_load_nord", s_mrd, 1'b0);
    tick();
    check1("t1_req", s_mrd, 1'b1);
    check32("t1_addr", s_maddr, 32'h0000_1000);
    tick();
    s_mval  = 1'b1;
    s_mdata = 32'hA5A5_0001;
    check1("t1_wait_nowr", s_wr, 1'b0);
    tick();
    s_mval = 1'b0;
    check1("t1_push", s_wr, 1'b1);
    check32("t1_din", s_din, 32'hA5A5_0001);
    tick();
    check32("t1_cnt", 32'(s_cnt), 32'd1);
    check1("t1_idle", s_busy, 1'b0);
    check1("t1_uerr", s_err, 1'b0);

    // Four beats across the 32-bit address wrap
    rd0  = rd_count;
    mrd0 = mrd_count;
    addr_fifo_empty = 1'b0;
    load_addr(32'hFFFF_FFF8, 1'b1, "t2");
    do_beat(32'hFFFF_FFF8, 32'h1111_0000, "t2b0");
    do_beat(32'hFFFF_FFFC, 32'h1111_0001, "t2b1");
    do_beat(32'h0000_0000, 32'h1111_0002, "t2b2");
    do_beat(32'h0000_0004, 32'h1111_0003, "t2b3");
    tick();
    check32("t2_one_pop", 32'(rd_count - rd0), 32'd1);
    check32("t2_four_rd", 32'(mrd_count - mrd0), 32'd4);
    check32("t2_cnt", 32'(vctr_fetch_cnt), 32'd4);
    check1("t2_idle", fetch_busy, 1'b0);

    // Vector FIFO full for 10 cycles while in REQ
    addr_fifo_empty = 1'b0;
    load_addr(32'h0000_2000, 1'b1, "t3");
    vector_fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check1("t3_hold_nord", master_rd, 1'b0);
    end
    vector_fifo_full = 1'b0;
    #1;
    check1("t3_rd_release", master_rd, 1'b1);
    for (int b = 0; b < 4; b++)
      do_beat(32'h0000_2000 + 32'(4 * b), 32'h2222_0000 + 32'(b), "t3b");
    tick();
    check32("t3_cnt", 32'(vctr_fetch_cnt), 32'd8);

    // run_program drops during beat 2 with three addresses queued
    addr_fifo_empty = 1'b0;
    load_addr(32'h0000_3000, 1'b0, "t4a");
    for (int b = 0; b < 4; b++) begin
      if (b == 2) run_program = 1'b0;
      do_beat(32'h0000_3000 + 32'(4 * b), 32'h3300_0000 + 32'(b), "t4ab");
    end
    rd0 = rd_count;
    repeat (6) tick();
    check32("t4_no_pop_stopped", 32'(rd_count - rd0), 32'd0);
    check1("t4_idle_stopped", fetch_busy, 1'b0);
    check1("t4_not_done", fetch_done, 1'b0);
    end_program = 1'b1;
    run_program = 1'b1;
    load_addr(32'h0000_4000, 1'b0, "t4b");
    for (int b = 0; b < 4; b++)
      do_beat(32'h0000_4000 + 32'(4 * b), 32'h4400_0000 + 32'(b), "t4bb");
    load_addr(32'h0000_5000, 1'b1, "t4c");
    for (int b = 0; b < 4; b++)
      do_beat(32'h0000_5000 + 32'(4 * b), 32'h5500_0000 + 32'(b), "t4cb");
    check1("t4_done_busy", fetch_done, 1'b0);
    tick();
    tick();
    check1("t4_done", fetch_done, 1'b1);
    check32("t4_pops", 32'(rd_count - rd0), 32'd2);
    check32("t4_cnt", 32'(vctr_fetch_cnt), 32'd20);
    check1("t4_uerr", unexpected_rsp_err, 1'b0);
    end_program = 1'b0;
    tick();
    check1("t4_done_clear", fetch_done, 1'b0);

    // Response outside WAIT
    master_data_in     = 32'h0000_1234;
    master_data_in_val = 1'b1;
    tick();
    master_data_in_val = 1'b0;
    check1("t5_nowr", vctr_fifo_wr, 1'b0);
    check1("t5_uerr", unexpected_rsp_err, 1'b1);
    check32("t5_din_held", vctr_fifo_din, 32'h5500_0003);
    check32("t5_cnt", 32'(vctr_fetch_cnt), 32'd20);
    tick();
    check1("t5_uerr_sticky", unexpected_rsp_err, 1'b1);
    reset = 1'b0;
    tick();
    check_all_zero("t5_rst");
    reset              = 1'b1;
    master_data_in_val = 1'b1;
    tick();
    master_data_in_val = 1'b0;
    check1("t5_hold_ignored", unexpected_rsp_err, 1'b0);
    master_data_in_val = 1'b1;
    tick();
    master_data_in_val = 1'b0;
    check1("t5_after_hold", unexpected_rsp_err, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Timeout path, then reset mid-WAIT
    addr_fifo_empty = 1'b0;
    load_addr(32'h0000_6000, 1'b1, "t6");
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 40 && master_rd !== 1'b1; i++) tick();
    check1("t6_rd", master_rd, 1'b1);
    check32("t6_addr", master_addr, 32'h0000_6000);
    repeat (16) tick();
    check1("t6_wait16_nowr", vctr_fifo_wr, 1'b0);
    check1("t6_wait16_terr", timeout_err, 1'b0);
    tick();
    check1("t6_to_wr", vctr_fifo_wr, 1'b1);
    check32("t6_to_din", vctr_fifo_din, 32'hDEAD_BEEF);
    check1("t6_terr", timeout_err, 1'b1);
    master_data_in     = 32'h0BAD_0BAD;
    master_data_in_val = 1'b1;
    tick();
    master_data_in_val = 1'b0;
    check1("t6_late_uerr", unexpected_rsp_err, 1'b1);
`endif
    for (int i = 0; i < 40 && master_rd !== 1'b1; i++) tick();
    check1("t6_req", master_rd, 1'b1);
    tick();
    check1("t6_in_wait", fetch_busy, 1'b1);
    reset = 1'b0;
    tick();
    check_all_zero("t6_rst");
    reset              = 1'b1;
    master_data_in     = 32'hCAFE_0000;
    master_data_in_val = 1'b1;
    tick();
    master_data_in_val = 1'b0;
    check1("t6_late_ignored", unexpected_rsp_err, 1'b0);
    check1("t6_late_nowr", vctr_fifo_wr, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
